// File: rtl/spi_register_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_register_bank
// Purpose  : Byte-oriented, LSB-first serial slave clocked by sclk. The first
//            byte after a transaction reset loads an address pointer. Every
//            later byte is a simultaneous read and write at that pointer,
//            which then auto-increments and wraps from 0xFF to 0x00.
//            Map: 0x00 reserved, 0x01 trigger_channel_mask, 0x02 instruction,
//            0x03 mode, BASE_CH.. channel bytes (7 per channel), rest read 0.
// Ports    : sclk       - serial clock, all state changes on its rising edge
//            rstn       - asynchronous active-low reset (whole block)
//            iclk       - asynchronous active-high transaction reset
//                         (config registers retained)
//            ch0..ch7   - read-only channel words, sampled live
//            serial_in  - serial data in, LSB first
//            serial_out - serial data out, LSB first
// Revision : 1.0 - initial release
// ============================================================================
module spi_register_bank #(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 50,
    parameter int BASE_CH = 4
) (
    input  logic            sclk,
    input  logic            rstn,
    input  logic            iclk,
    input  logic [CH_W-1:0] ch0,
    input  logic [CH_W-1:0] ch1,
    input  logic [CH_W-1:0] ch2,
    input  logic [CH_W-1:0] ch3,
    input  logic [CH_W-1:0] ch4,
    input  logic [CH_W-1:0] ch5,
    input  logic [CH_W-1:0] ch6,
    input  logic [CH_W-1:0] ch7,
    input  logic            serial_in,
    output logic            serial_out
);

    localparam int         c_BYTES_PER_CH = (CH_W + 7) / 8;
    localparam int         c_PAD_W        = 8 * c_BYTES_PER_CH;
    localparam int         c_MAP_BYTES    = NUM_CH * c_BYTES_PER_CH;
    localparam logic [7:0] c_ADDR_TRIG    = 8'h01;
    localparam logic [7:0] c_ADDR_INSTR   = 8'h02;
    localparam logic [7:0] c_ADDR_MODE    = 8'h03;

    logic [7:0]      r_addr_ptr;
    logic [2:0]      r_bit_cnt;
    logic [6:0]      r_shift_in;
    logic            r_addr_phase;
    logic            r_serial_out;
    logic [7:0]      r_trig_mask;
    logic [7:0]      r_instruction;
    logic [7:0]      r_mode;

    logic [CH_W-1:0] w_ch [8];
    logic [c_MAP_BYTES-1:0][7:0] w_map;
    logic [7:0]      w_rd_byte;
    logic [7:0]      w_rx_byte;
    logic            w_byte_done;
    logic            w_txn_rst_n;

    assign w_ch[0] = ch0;
    assign w_ch[1] = ch1;
    assign w_ch[2] = ch2;
    assign w_ch[3] = ch3;
    assign w_ch[4] = ch4;
    assign w_ch[5] = ch5;
    assign w_ch[6] = ch6;
    assign w_ch[7] = ch7;

    // Flatten every channel into its byte slots; the top byte of each channel
    // is zero-padded above bit CH_W-1.
    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            logic [c_PAD_W-1:0] w_pad;
            assign w_pad = c_PAD_W'(w_ch[k]);
            for (genvar b = 0; b < c_BYTES_PER_CH; b++) begin : g_byte
                assign w_map[k*c_BYTES_PER_CH + b] = w_pad[8*b +: 8];
            end
        end
    endgenerate

    // Read data for the current pointer, built from live register/channel
    // values so channel inputs may change between bytes.
    always_comb begin
        w_rd_byte = 8'h00;
        case (r_addr_ptr)
            c_ADDR_TRIG:  w_rd_byte = r_trig_mask;
            c_ADDR_INSTR: w_rd_byte = r_instruction;
            c_ADDR_MODE:  w_rd_byte = r_mode;
            default: begin
                for (int i = 0; i < c_MAP_BYTES; i++) begin
                    if ({24'd0, r_addr_ptr} == 32'(BASE_CH + i)) begin
                        w_rd_byte = w_map[i];
                    end
                end
            end
        endcase
    end

    assign w_byte_done = (r_bit_cnt == 3'd7);
    // Bits 0..6 already sit in the shift register; bit 7 arrives on this edge.
    assign w_rx_byte   = {serial_in, r_shift_in};

    // rstn and iclk clear the transaction state to identical values, so they
    // share one asynchronous clear; a partial byte is simply dropped.
    assign w_txn_rst_n = rstn & ~iclk;

    always_ff @(posedge sclk or negedge w_txn_rst_n) begin
        if (!w_txn_rst_n) begin
            r_addr_ptr   <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_shift_in   <= 7'h00;
            r_addr_phase <= 1'b1;
            r_serial_out <= 1'b0;
        end else begin
            // Right shift: after seven edges bit j of the byte is in [j].
            r_shift_in   <= {serial_in, r_shift_in[6:1]};
            r_serial_out <= r_addr_phase ? 1'b0 : w_rd_byte[r_bit_cnt];
            r_bit_cnt    <= r_bit_cnt + 3'd1;
            if (w_byte_done) begin
                if (r_addr_phase) begin
                    r_addr_ptr   <= w_rx_byte;
                    r_addr_phase <= 1'b0;
                end else begin
                    r_addr_ptr <= r_addr_ptr + 8'd1;
                end
            end
        end
    end

    // Config registers survive iclk. They update only at byte completion, so
    // the outgoing byte always carries the pre-write value.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            r_trig_mask   <= 8'h00;
            r_instruction <= 8'h00;
            r_mode        <= 8'h00;
        end else if (w_byte_done && !r_addr_phase) begin
            case (r_addr_ptr)
                c_ADDR_TRIG:  r_trig_mask   <= w_rx_byte;
                c_ADDR_INSTR: r_instruction <= w_rx_byte;
                c_ADDR_MODE:  r_mode        <= w_rx_byte;
                default:      ;
            endcase
        end
    end

    assign serial_out = r_serial_out;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_register_bank
// Purpose  : Self-checking bench for spi_register_bank. Drives sclk pulses
//            directly and compares every received byte against a
//            transaction-level model of the register map.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_register_bank;

    logic        sclk      = 1'b0;
    logic        rstn      = 1'b1;
    logic        iclk      = 1'b0;
    logic        serial_in = 1'b0;
    logic        serial_out;
    logic [49:0] ch_val [8];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [7:0] m_cfg [4];
    logic [7:0] m_ptr;
    logic       m_addr_phase;

    logic [7:0] c_ch0 [7] = '{8'hD3, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'hD2, 8'h02};
    logic [7:0] c_ch3 [7] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};

    spi_register_bank dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .iclk       (iclk),
        .ch0        (ch_val[0]),
        .ch1        (ch_val[1]),
        .ch2        (ch_val[2]),
        .ch3        (ch_val[3]),
        .ch4        (ch_val[4]),
        .ch5        (ch_val[5]),
        .ch6        (ch_val[6]),
        .ch7        (ch_val[7]),
        .serial_in  (serial_in),
        .serial_out (serial_out)
    );

    // Byte value at address a: config registers, then 7-byte channel words.
    function automatic logic [7:0] model_rd(input logic [7:0] a);
        int          off;
        logic [49:0] t;
        if (a >= 8'd1 && a <= 8'd3) return m_cfg[a[1:0]];
        off = int'(a) - 4;
        if (off < 0 || off >= 56) return 8'h00;
        t = ch_val[off / 7] >> (8 * (off % 7));
        return t[7:0];
    endfunction

    task automatic model_step(input logic [7:0] din, output logic [7:0] exp_rd);
        if (m_addr_phase) begin
            exp_rd       = 8'h00;
            m_ptr        = din;
            m_addr_phase = 1'b0;
        end else begin
            exp_rd = model_rd(m_ptr);
            if (m_ptr >= 8'd1 && m_ptr <= 8'd3) m_cfg[m_ptr[1:0]] = din;
            m_ptr = m_ptr + 8'd1;
        end
    endtask

    task automatic send_bits(input logic [7:0] din, input int n, output logic [7:0] dout);
        dout = 8'h00;
        for (int j = 0; j < n; j++) begin
            serial_in = din[j];
            #5 sclk = 1'b1;
            #1 dout[j] = serial_out;
            #4 sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] din, output logic [7:0] got, output logic [7:0] exp_rd);
        send_bits(din, 8, got);
        model_step(din, exp_rd);
    endtask

    task automatic pulse_iclk();
        #2 iclk = 1'b1;
        #2 iclk = 1'b0;
        #2;
        m_ptr        = 8'h00;
        m_addr_phase = 1'b1;
    endtask

    task automatic pulse_rstn();
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
        #2;
        m_ptr        = 8'h00;
        m_addr_phase = 1'b1;
        for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] got, exp_rd;
        pulse_rstn();
        n_checks++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_serial_out: got %b expected 0", serial_out);
        end
        xfer(8'h01, got, exp_rd);
        for (int i = 0; i < 3; i++) begin
            xfer(8'h00, got, exp_rd);
            n_checks++;
            if (got !== 8'h00 || got !== exp_rd) begin
                n_fail++;
                $display("FAIL reset_cfg%0d: got %02h expected 00", i + 1, got);
            end
        end
    endtask

    task automatic test_cfg_write();
        logic [7:0] got, exp_rd, v;
        pulse_iclk();
        xfer(8'h01, got, exp_rd);
        for (int i = 1; i <= 3; i++) xfer(8'(i * 16), got, exp_rd);
        pulse_iclk();
        xfer(8'h01, got, exp_rd);
        for (int i = 1; i <= 3; i++) begin
            xfer(8'(i * 16), got, exp_rd);
            n_checks++;
            if (got !== 8'(i * 16) || got !== exp_rd) begin
                n_fail++;
                $display("FAIL cfg_readback%0d: got %02h expected %02h", i, got, 8'(i * 16));
            end
        end
        // Random writes, then read back with fresh random data each round
        for (int r = 0; r < 3; r++) begin
            pulse_iclk();
            xfer(8'h01, got, exp_rd);
            for (int i = 1; i <= 3; i++) begin
                v = 8'($urandom);
                xfer(v, got, exp_rd);
                n_checks++;
                if (got !== exp_rd) begin
                    n_fail++;
                    $display("FAIL cfg_random r%0d reg%0d: got %02h expected %02h", r, i, got, exp_rd);
                end
            end
        end
    endtask

    task automatic test_channels();
        logic [7:0] got, exp_rd;
        for (int k = 0; k < 8; k++) ch_val[k] = 50'({$urandom(), $urandom()});
        ch_val[0] = 50'h2D2D2D2D2D2D3;
        ch_val[3] = '1;
        pulse_iclk();
        xfer(8'h04, got, exp_rd);
        for (int i = 0; i < 56; i++) begin
            // Channel inputs may change between bytes
            if (i == 20) ch_val[6] = 50'({$urandom(), $urandom()});
            if (i == 30) ch_val[7] = 50'({$urandom(), $urandom()});
            xfer(8'($urandom), got, exp_rd);
            n_checks++;
            if (got !== exp_rd) begin
                n_fail++;
                $display("FAIL chan_byte addr=%02h: got %02h expected %02h", 8'(4 + i), got, exp_rd);
            end
            if (i < 7) begin
                n_checks++;
                if (got !== c_ch0[i]) begin
                    n_fail++;
                    $display("FAIL ch0_byte%0d: got %02h expected %02h", i, got, c_ch0[i]);
                end
            end
            if (i >= 21 && i < 28) begin
                n_checks++;
                if (got !== c_ch3[i - 21]) begin
                    n_fail++;
                    $display("FAIL ch3_byte%0d: got %02h expected %02h", i - 21, got, c_ch3[i - 21]);
                end
            end
        end
    endtask

    task automatic test_invalid();
        logic [7:0] got, exp_rd;
        logic [7:0] addrs [4] = '{8'h3C, 8'h80, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            pulse_iclk();
            xfer(addrs[i], got, exp_rd);
            xfer(8'($urandom), got, exp_rd);
            n_checks++;
            if (got !== 8'h00 || got !== exp_rd) begin
                n_fail++;
                $display("FAIL invalid_rd addr=%02h: got %02h expected 00", addrs[i], got);
            end
        end
        // Pointer wrap FF -> 00 -> 01
        pulse_iclk();
        xfer(8'hFF, got, exp_rd);
        for (int i = 0; i < 3; i++) begin
            xfer(i == 2 ? m_cfg[1] : 8'($urandom), got, exp_rd);
            n_checks++;
            if (got !== exp_rd) begin
                n_fail++;
                $display("FAIL wrap_rd step%0d: got %02h expected %02h", i, got, exp_rd);
            end
        end
        // Config registers unaffected by the invalid-address writes
        pulse_iclk();
        xfer(8'h01, got, exp_rd);
        for (int i = 1; i <= 3; i++) begin
            xfer(m_cfg[i], got, exp_rd);
            n_checks++;
            if (got !== exp_rd) begin
                n_fail++;
                $display("FAIL invalid_cfg_keep reg%0d: got %02h expected %02h", i, got, exp_rd);
            end
        end
    endtask

    task automatic test_rstn_midbyte();
        logic [7:0] got, exp_rd;
        pulse_iclk();
        xfer(8'h02, got, exp_rd);
        xfer(8'h55, got, exp_rd);
        pulse_iclk();
        xfer(8'h02, got, exp_rd);
        send_bits(8'hAA, 3, got);
        n_checks++;
        if (serial_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rstn_pre_bit2: got %b expected 1", serial_out);
        end
        pulse_rstn();
        n_checks++;
        if (serial_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rstn_mid_serial_out: got %b expected 0", serial_out);
        end
        xfer(8'h02, got, exp_rd);
        xfer(8'h00, got, exp_rd);
        n_checks++;
        if (got !== 8'h00 || got !== exp_rd) begin
            n_fail++;
            $display("FAIL rstn_mid_instr: got %02h expected 00", got);
        end
    endtask

    task automatic test_iclk_midbyte();
        logic [7:0] got, exp_rd, v1;
        v1 = 8'($urandom_range(1, 255));
        pulse_iclk();
        xfer(8'h01, got, exp_rd);
        xfer(v1, got, exp_rd);
        pulse_iclk();
        xfer(8'h01, got, exp_rd);
        send_bits(8'($urandom), 4, got);
        pulse_iclk();
        xfer(8'h02, got, exp_rd);
        xfer(8'hAA, got, exp_rd);
        pulse_iclk();
        xfer(8'h01, got, exp_rd);
        xfer(m_cfg[1], got, exp_rd);
        n_checks++;
        if (got !== v1 || got !== exp_rd) begin
            n_fail++;
            $display("FAIL iclk_mid_trig: got %02h expected %02h", got, v1);
        end
        xfer(m_cfg[2], got, exp_rd);
        n_checks++;
        if (got !== 8'hAA || got !== exp_rd) begin
            n_fail++;
            $display("FAIL iclk_mid_instr: got %02h expected aa", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, exp_rd, a;
        int         n;
        for (int r = 0; r < 20; r++) begin
            a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(240, 255))
                                             : 8'($urandom_range(0, 70));
            n = $urandom_range(1, 12);
            if ($urandom_range(0, 1) == 1) ch_val[$urandom_range(0, 7)] = 50'({$urandom(), $urandom()});
            pulse_iclk();
            xfer(a, got, exp_rd);
            for (int i = 0; i < n; i++) begin
                xfer(8'($urandom), got, exp_rd);
                n_checks++;
                if (got !== exp_rd) begin
                    n_fail++;
                    $display("FAIL b2b r%0d start=%02h byte%0d: got %02h expected %02h",
                             r, a, i, got, exp_rd);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 8; k++) ch_val[k] = '0;
        for (int i = 0; i < 4; i++) m_cfg[i] = 8'h00;
        m_ptr        = 8'h00;
        m_addr_phase = 1'b1;
        #5;
        test_reset();
        test_cfg_write();
        test_channels();
        test_invalid();
        test_rstn_midbyte();
        test_iclk_midbyte();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_register_bank.md
Name: spi_register_bank

Overview:
- Byte-oriented, LSB-first serial slave clocked by sclk.
- After a transaction reset, the first byte received loads an 8-bit address pointer.
- Each later byte is a simultaneous read and write at the pointer, which then auto-increments.
- Exposes three writable 8-bit configuration registers, plus eight read-only 50-bit channel words mapped as byte-addressable space.

Parameters:
- NUM_CH, 8, number of 50-bit channel inputs.
- CH_W, 50, channel word width; each channel occupies ceil(CH_W/8)=7 byte addresses.
- BASE_CH, 4, first channel byte address.

Ports:
- sclk  input  1  serial clock; the only clock, all state changes on its rising edge.
- rstn  input  1  asynchronous active-low reset.
- iclk  input  1  transaction reset strobe; level-sensitive, active-high, asynchronous; asserted only while sclk is low.
- ch0..ch7  input  50 each  read-only channel data, sampled live.
- serial_in  input  1  serial data in, LSB first.
- serial_out  output  1  serial data out, LSB first.

Behaviour:
- Register map:
  - 0x00: reserved; reads 0, writes ignored.
  - 0x01: trigger_channel_mask, R/W.
  - 0x02: instruction, R/W.
  - 0x03: mode, R/W.
  - 0x04–0x3B: channel bytes. Address 4+7k+b returns chk[8b+7:8b] for b=0..5; b=6 returns {6'b0, chk[49:48]}. Writes ignored.
  - 0x3C–0xFF: invalid; reads 0, writes ignored.
- State:
  - addr_ptr[7:0]
  - bit_cnt[2:0]
  - shift_in[7:0]
  - addr_phase flag
  - the three config registers
  - serial_out register
- rstn low (async):
  - all config registers = 0x00, addr_ptr = 0, bit_cnt = 0, addr_phase = 1, serial_out = 0.
- iclk high (async):
  - clears addr_ptr, bit_cnt, shift_in, serial_out, and sets addr_phase = 1.
  - Config registers are retained.
  - rstn has priority when both are asserted.
- Each sclk rising edge, with neither reset active:
  - shift_in[bit_cnt] <= serial_in.
  - serial_out <= 0 if addr_phase; else serial_out <= rd_byte(addr_ptr)[bit_cnt].
  - bit_cnt increments.
  - Bit j of a byte is therefore visible on serial_out shortly after the j-th rising edge of that byte.
- On the edge that completes a byte (bit_cnt==7):
  - Assembled byte is {serial_in, shift_in[6:0]}.
  - If addr_phase: addr_ptr <= byte, addr_phase <= 0.
  - Else: if addr_ptr ∈ {1,2,3}, that register <= byte; then addr_ptr <= addr_ptr+1.
  - addr_ptr wraps from 0xFF to 0x00.
- Read-before-write: during a data byte, serial_out shifts out the register's value from before that byte's write. The write takes effect only at byte completion.
- rd_byte is combinational from the current register and ch values, so channel inputs may change between bytes.
- Reset mid-byte: either reset discards the partial byte; no register is written.

Test Plan:
- rstn pulse, then address 0x01, then write 0x10, 0x20, 0x30 → registers 1/2/3 = 0x10, 0x20, 0x30. Pulse iclk.
- Address 0x01, then resend 0x10, 0x20, 0x30 → each byte's serial_out bits equal 0x10, 0x20, 0x30 (old values); the values are unchanged afterwards.
- Set ch0 = 50'h2D2D2D2D2D2D3 and ch3 = all ones. Pulse iclk, address 0x04, then 56 dummy bytes:
  - ch0 reads D3, D2, D2, D2, D2, D2, 02.
  - Channel bytes continue contiguously through ch7; ch3 reads FF×6, then 03.
- Address 0x3C, 0x80 and 0xFF, each followed by one dummy byte → reads 0x00, and no register changes.
- Write 0x55 to address 0x02, then assert rstn mid-byte of a later write → instruction = 0x00 and serial_out = 0.
- Address 0x01, 4 bits, then iclk pulse, then address 0x02 and write 0xAA → instruction = 0xAA; trigger_channel_mask is unchanged.
